// File: rtl/down_timer.sv
// down_timer: loadable synchronous down counter with a one-cycle terminal-count
// pulse and optional auto-reload, used as a delay / period generator.
module down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] reload_next;
   logic [WIDTH-1:0] count_next;
   logic             tc_next;

   // State register plus the registered count, reload value and terminal pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         tc         <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         reload_reg <= reload_next;
         tc         <= tc_next;
      end
   end

   // Next-state logic: load beats everything; decrement only while running and enabled;
   // the count==0 branch is only reachable after an auto-reload terminal event.
   always_comb begin
      state_next  = state;
      count_next  = count;
      reload_next = reload_reg;
      tc_next     = 1'b0;
      if (load) begin
         count_next  = load_val;
         reload_next = load_val;
         state_next  = (load_val != '0) ? RUN : IDLE;
      end else if (state == RUN && en) begin
         if (count == '0) begin
            count_next = reload_reg;
         end else if (count == WIDTH'(1)) begin
            count_next = '0;
            tc_next    = 1'b1;
            state_next = auto_reload ? RUN : IDLE;
         end else begin
            count_next = count - WIDTH'(1);
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the timer kept in this bench.
module tb_down_timer;

   logic       clk;
   logic       rst;
   logic       load;
   logic [3:0] load_val;
   logic       en;
   logic       auto_reload;
   logic [3:0] count;
   logic       tc;
   logic       busy;

   int numCompared;
   int numMismatched;

   // behavioural model: remaining value, period value, running flag, pulse
   int m_count;
   int m_reload;
   bit m_run;
   bit m_tc;

   down_timer #(.WIDTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(load_val),
      .en(en),
      .auto_reload(auto_reload),
      .count(count),
      .tc(tc),
      .busy(busy)
   );

   // 10 ns free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_count  = 0;
      m_reload = 0;
      m_run    = 0;
      m_tc     = 0;
   endtask

   // One clock edge of the timer described in words: a load restarts the timer,
   // an enabled running timer either reloads from zero or moves one step closer
   // to zero, and reaching zero fires the pulse and decides whether to keep going.
   task automatic modelEdge();
      m_tc = 0;
      if (load) begin
         m_count  = load_val;
         m_reload = load_val;
         m_run    = (load_val != 0);
      end else if (m_run && en) begin
         if (m_count == 0) begin
            m_count = m_reload;
         end else begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_tc  = 1;
               m_run = auto_reload;
            end
         end
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".count"}, 32'(count), 32'(m_count));
      checkOutput({tag, ".tc"},    32'(tc),    32'(m_tc));
      checkOutput({tag, ".busy"},  32'(busy),  32'(m_run));
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare against the model.
   task automatic applyStimulus(input string tag, input logic ld, input logic [3:0] lv,
                                input logic e, input logic ar);
      load        = ld;
      load_val    = lv;
      en          = e;
      auto_reload = ar;
      @(posedge clk);
      modelEdge();
      #1;
      checkModel(tag);
   endtask

   // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
   task automatic pulseReset(input string tag);
      #1;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput({tag, ".count"}, 32'(count), 32'd0);
      checkOutput({tag, ".tc"},    32'(tc),    32'd0);
      checkOutput({tag, ".busy"},  32'(busy),  32'd0);
      rst = 1'b0;
   endtask

   initial begin
      int edges;
      bit seen;
      logic [3:0] gateEn  [6] = '{1, 0, 0, 1, 1, 1};
      int         gateCnt [6] = '{3, 3, 3, 2, 1, 0};

      numCompared   = 0;
      numMismatched = 0;
      rst         = 1'b1;
      load        = 1'b0;
      load_val    = '0;
      en          = 1'b0;
      auto_reload = 1'b0;
      modelReset();

      #2;
      checkOutput("reset.count", 32'(count), 32'd0);
      checkOutput("reset.tc",    32'(tc),    32'd0);
      checkOutput("reset.busy",  32'(busy),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // one-shot countdown from 3
      applyStimulus("oneshot.load", 1, 4'd3, 1, 0);
      checkOutput("oneshot.first", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) applyStimulus("oneshot.run", 0, 4'd0, 1, 0);
      checkOutput("oneshot.tc", 32'(tc), 32'd1);
      checkOutput("oneshot.busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus("oneshot.hold", 0, 4'd0, 1, 0);
      checkOutput("oneshot.stay0", 32'(count), 32'd0);

      // auto-reload with period 3
      applyStimulus("auto.load", 1, 4'd2, 1, 1);
      for (int i = 0; i < 9; i++) begin
         applyStimulus("auto.run", 0, 4'd0, 1, 1);
         checkOutput("auto.seq", 32'(count), 32'((2 - ((i + 1) % 3))));
         checkOutput("auto.busy", 32'(busy), 32'd1);
      end

      // enable gating from 4
      applyStimulus("gate.load", 1, 4'd4, 0, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus("gate.run", 0, 4'd0, gateEn[i][0], 0);
         checkOutput("gate.seq", 32'(count), 32'(gateCnt[i]));
      end
      checkOutput("gate.tc", 32'(tc), 32'd1);

      // load wins over a simultaneous terminal event
      applyStimulus("prio.load", 1, 4'd2, 1, 0);
      applyStimulus("prio.dec", 0, 4'd0, 1, 0);
      applyStimulus("prio.hit", 1, 4'd9, 1, 0);
      checkOutput("prio.count", 32'(count), 32'd9);
      checkOutput("prio.tc", 32'(tc), 32'd0);
      checkOutput("prio.busy", 32'(busy), 32'd1);

      // zero load never runs
      applyStimulus("zero.load", 1, 4'd0, 1, 1);
      for (int i = 0; i < 4; i++) applyStimulus("zero.hold", 0, 4'd0, 1, 1);

      // max load: exactly 15 enabled edges to the pulse, no wrap afterwards
      applyStimulus("max.load", 1, 4'd15, 1, 0);
      edges = 0;
      seen  = 0;
      while (!seen && edges < 40) begin
         applyStimulus("max.run", 0, 4'd0, 1, 0);
         edges++;
         if (tc) seen = 1;
      end
      checkOutput("max.edges", 32'(edges), 32'd15);
      for (int i = 0; i < 3; i++) applyStimulus("max.nowrap", 0, 4'd0, 1, 0);

      // asynchronous reset mid-run at count 3
      applyStimulus("rstmid.load", 1, 4'd5, 1, 0);
      applyStimulus("rstmid.run", 0, 4'd0, 1, 0);
      applyStimulus("rstmid.run", 0, 4'd0, 1, 0);
      checkOutput("rstmid.at3", 32'(count), 32'd3);
      pulseReset("rstmid");
      for (int i = 0; i < 3; i++) applyStimulus("rstmid.after", 0, 4'd0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulseReset("rand.rst");
         end else begin
            applyStimulus("rand",
                          ($urandom_range(0, 9) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 1) == 1));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
